dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter that shares the single-ported, registered-read data memory between the core load/store unit (port 0) and a debug/DMA requester (port 1). It latches one granted request at a time, sequences the DMEM write-enable, address and write-data lines, and returns read data and completion status to the owning port. It sits between both requesters and the DMEM instance, which it drives directly.

## Interface
- `REG_WIDTH`, default 32: data word width.
- `DMEM_ADDR_WIDTH`, default 10: byte address width.
- `DMEM_DEPTH`, default 1024: DMEM size in bytes.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `m0_req`, `m1_req`  in  1  request. Held with its qualifiers until the matching `gnt`.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  DMEM_ADDR_WIDTH  byte address.
- `m0_wdata`, `m1_wdata`  in  REG_WIDTH  write data.
- `m0_gnt`, `m1_gnt`  out  1  one-cycle accept pulse.
- `m0_done`, `m1_done`  out  1  one-cycle completion pulse.
- `m0_err`, `m1_err`  out  1  qualifies `done`: request was rejected.
- `m0_rdata`, `m1_rdata`  out  REG_WIDTH  read data, valid only with `done` on a read.
- `dmem_wr_en`  out  1  DMEM write enable.
- `dmem_addr`  out  DMEM_ADDR_WIDTH  DMEM address.
- `dmem_wr_data`  out  REG_WIDTH  DMEM write data.
- `dmem_rdata`  in  REG_WIDTH  DMEM registered read data; valid the cycle after the address is presented.

## Operation
- **FSM states:** IDLE, ACCESS, RESP.
- **IDLE:**
  - If any `req` is high, assert the selected port's `gnt` combinationally in the same cycle.
  - On that edge, latch port id, `we`, `addr` and `wdata`, then go to ACCESS.
  - With no request, stay in IDLE.
- **ACCESS:**
  - Drive `dmem_addr` = latched address.
  - Drive `dmem_wr_en` = latched `we` AND NOT err.
  - Drive `dmem_wr_data` = latched data.
  - Go to RESP unconditionally.
- **RESP:**
  - Pulse the owner's `done`.
  - Owner's `rdata` = `dmem_rdata` on a valid read; 0 on a write or on error.
  - Go to IDLE unconditionally.
- **err condition** (computed from the latched address): `addr[1:0] != 0`, or `addr > DMEM_DEPTH-4`.
  - An errored write never asserts `dmem_wr_en`.
  - An errored read returns `rdata` = 0.
  - `done` and `err` pulse together.
- **Outside ACCESS:** `dmem_wr_en` = 0. `dmem_addr` and `dmem_wr_data` hold their last latched values.
- **Non-owner port:** `gnt`, `done`, `err` = 0 and `rdata` = 0.
- **Arbitration:** fixed priority, port 0 wins; see Configuration for the round-robin option.
- **Request changes before `gnt`:** a requester that drops `req` before its `gnt` is simply not served; no state is kept for it.
- **Reset (asynchronous, any state):**
  - FSM returns to IDLE; all latches clear to 0.
  - All outputs go to 0 immediately. This includes `dmem_wr_en`, so an in-flight write in ACCESS is suppressed if reset asserts before the clock edge.
  - The pending access is discarded; no `done` is issued for it.

## Timing
- Grant in cycle G. DMEM driven in G+1, with the write or read-address capture at the end of G+1.
- `done`/`rdata` in G+2. Next grant earliest in G+3.
- Peak throughput: one access per 3 cycles.
- `gnt` is combinational from `req` in IDLE. `done`, `err` and `rdata` are combinational from state plus `dmem_rdata`.
- Requests arriving during ACCESS/RESP wait. They are evaluated in the next IDLE cycle.
- A port may re-request in the same cycle its `done` pulses. That request is seen in the following IDLE.

## Configuration
- **Macro `DMEM_ARB_RR_EN` undefined:** fixed priority. Port 0 always wins simultaneous requests, so port 1 can starve.
- **Macro `DMEM_ARB_RR_EN` defined:** round robin.
  - A `last` flop records the most recently granted port.
  - On simultaneous requests, grant the port not equal to `last`.
  - With a single requester, grant it regardless of `last`.
  - `last` resets to 1, so port 0 wins the first conflict.

## Test plan
- **Reset values:** assert `reset_n`=0 mid-ACCESS of a port-0 write to 0x10 -> `dmem_wr_en` drops to 0 at once, no `done`, all outputs 0; after release the FSM is in IDLE.
- **Write then read:** port 0 writes 0xDEADBEEF to 0x20, then reads 0x20 -> `gnt` in G, `dmem_wr_en`=1 only in G+1, `m0_done` in G+2; the read returns `m0_rdata`=0xDEADBEEF with `done` two cycles after its grant.
- **Misaligned / out-of-range:**
  - Port 1 writes to 0x22 -> `m1_done`=`m1_err`=1 in G+2, `dmem_wr_en` never high; a later read of 0x20 is unchanged.
  - Port 1 reads `DMEM_DEPTH`-2 -> `err`=1, `rdata`=0.
- **Conflict, fixed priority:** both ports request continuously -> only `m0_gnt` pulses, every 3 cycles; `m1_gnt` never asserts.
- **Conflict with `DMEM_ARB_RR_EN`:** both ports request continuously -> grants alternate 0,1,0,1 every 3 cycles; with only port 1 requesting, port 1 is granted back to back.
- **Request drop:** port 1 raises `req` during port 0's ACCESS and drops it before IDLE -> no `m1_gnt`, FSM stays in IDLE.

Source files
------------

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-ported, registered-read data memory between the core
// load/store unit (port 0) and a debug/DMA requester (port 1). One request is
// accepted at a time. Each access takes three cycles:
//   - grant (IDLE)
//   - DMEM drive (ACCESS)
//   - completion (RESP)
//
// Parameters:
//   REG_WIDTH        data word width
//   DMEM_ADDR_WIDTH  byte address width
//   DMEM_DEPTH       DMEM size in bytes
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   mX_req/we/addr/wdata          request and qualifiers from port X
//   mX_gnt                        one-cycle accept pulse (combinational in IDLE)
//   mX_done/err/rdata             completion pulse, reject flag, read data
//   dmem_wr_en/addr/wr_data       DMEM control, driven directly
//   dmem_rdata                    DMEM registered read data
//
// Build option:
//   DMEM_ARB_RR_EN  when defined, conflicting requests alternate round robin.
//                   Otherwise port 0 has fixed priority.
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int REG_WIDTH       = 32,
    parameter int DMEM_ADDR_WIDTH = 10,
    parameter int DMEM_DEPTH      = 1024
) (
    input  logic                       clk,
    input  logic                       reset_n,

    input  logic                       m0_req,
    input  logic                       m0_we,
    input  logic [DMEM_ADDR_WIDTH-1:0] m0_addr,
    input  logic [REG_WIDTH-1:0]       m0_wdata,
    output logic                       m0_gnt,
    output logic                       m0_done,
    output logic                       m0_err,
    output logic [REG_WIDTH-1:0]       m0_rdata,

    input  logic                       m1_req,
    input  logic                       m1_we,
    input  logic [DMEM_ADDR_WIDTH-1:0] m1_addr,
    input  logic [REG_WIDTH-1:0]       m1_wdata,
    output logic                       m1_gnt,
    output logic                       m1_done,
    output logic                       m1_err,
    output logic [REG_WIDTH-1:0]       m1_rdata,

    output logic                       dmem_wr_en,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
    output logic [REG_WIDTH-1:0]       dmem_wr_data,
    input  logic [REG_WIDTH-1:0]       dmem_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Highest legal word address. It is kept one bit wider than the address
    // so the comparison cannot wrap.
    localparam logic [DMEM_ADDR_WIDTH:0] MAX_ADDR =
        (DMEM_ADDR_WIDTH+1)'(DMEM_DEPTH - 4);

    logic [1:0]                 state;
    logic                       owner;
    logic                       lat_we;
    logic [DMEM_ADDR_WIDTH-1:0] lat_addr;
    logic [REG_WIDTH-1:0]       lat_wdata;

    logic any_req;
    logic sel_port1;
    logic addr_err;
    logic in_idle;
    logic in_access;
    logic in_resp;

`ifdef DMEM_ARB_RR_EN
    logic last_port;
`endif

    assign any_req   = m0_req | m1_req;
    assign in_idle   = (state == ST_IDLE);
    assign in_access = (state == ST_ACCESS);
    assign in_resp   = (state == ST_RESP);

    // Port selection. Port 1 wins when it is the only requester.
    // With round robin enabled, port 1 also wins a conflict if port 0 was
    // the most recent grant.
    always_comb begin
        sel_port1 = m1_req & ~m0_req;
`ifdef DMEM_ARB_RR_EN
        if (m0_req && m1_req) begin
            sel_port1 = (last_port == 1'b0);
        end
`endif
    end

    // Misaligned or past the last full word.
    assign addr_err = (lat_addr[1:0] != 2'b00) || ({1'b0, lat_addr} > MAX_ADDR);

    // Grants are gated with reset_n. This keeps them low while reset is
    // held, even though the FSM sits in IDLE during reset.
    assign m0_gnt = reset_n & in_idle & m0_req & ~sel_port1;
    assign m1_gnt = reset_n & in_idle & sel_port1;

    assign m0_done  = in_resp & ~owner;
    assign m1_done  = in_resp &  owner;
    assign m0_err   = m0_done & addr_err;
    assign m1_err   = m1_done & addr_err;
    assign m0_rdata = (m0_done && !lat_we && !addr_err) ? dmem_rdata : '0;
    assign m1_rdata = (m1_done && !lat_we && !addr_err) ? dmem_rdata : '0;

    // Address and data come straight from the latches. They therefore hold
    // their last latched value outside ACCESS. Only the write enable is
    // qualified by state.
    assign dmem_wr_en   = in_access & lat_we & ~addr_err;
    assign dmem_addr    = lat_addr;
    assign dmem_wr_data = lat_wdata;

    // Main sequencer.
    // In IDLE, the selected port's request is captured and the FSM moves to
    // ACCESS. It then steps through ACCESS and RESP unconditionally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            owner     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        owner     <= sel_port1;
                        lat_we    <= sel_port1 ? m1_we    : m0_we;
                        lat_addr  <= sel_port1 ? m1_addr  : m0_addr;
                        lat_wdata <= sel_port1 ? m1_wdata : m0_wdata;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: state <= ST_RESP;
                ST_RESP:   state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Records the most recent grant.
    // It resets to 1 so that port 0 wins the first conflict.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_port <= 1'b1;
        end else if (in_idle && any_req) begin
            last_port <= sel_port1;
        end
    end
`endif

endmodule
